caravel_input_conditioner: RTL and testbench

//   Parametrised Caravel-side input conditioner that sits between user_project_wrapper GPIOs and a game core.

---
 rtl/caravel_io_pkg.sv | 38 +++
 rtl/button_debouncer.sv | 83 ++++++++
 rtl/caravel_input_conditioner.sv | 115 +++++++++++
 tb/tb_caravel_input_conditioner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_io_pkg.sv
// -----------------------------------------------------------------------------
// caravel_io_pkg
//   Shared constants and types for the Caravel-side input conditioner.
//   - Default values for the conditioner parameters.
//   - GPIO index map of the user_project_wrapper pins this block serves.
//   - Reset-sequencer phase type and a counter-width helper.
// -----------------------------------------------------------------------------
package caravel_io_pkg;

   // Default parameter values
   localparam int DEF_NUM_BUTTONS    = 4;
   localparam int DEF_NUM_OUTPUTS    = 6;
   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_DEBOUNCE_COUNT = 250000;
   localparam int DEF_RESET_HOLD     = 16;

   // GPIO index map
   localparam int EXT_RESET_IO = 8;
   localparam int BTN_IO_BASE  = 9;
   localparam int OUT_IO_BASE  = 13;

   // Decision taken by the reset sequencer on each non-reset edge
   typedef enum logic [1:0] {
      RST_EXT  = 2'd0,   // synchronised external reset is low: reload the hold
      RST_HOLD = 2'd1,   // external reset released, hold counter still draining
      RST_RUN  = 2'd2    // hold finished: release design_reset
   } rst_phase_e;

   // Width of a counter that must represent 0..max_val. Never returns 0 so a
   // zero-length hold still gets a legal one-bit vector.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   One active-low button: synchroniser chain, debounce counter, stable level
//   flop and registered press/release pulses.
// Ports
//   clk          in   clock
//   srst         in   synchronous active-high reset
//   btn_n_raw_i  in   asynchronous active-low button pin (idle high)
//   pulse_en_i   in   pulses may be produced on this edge (design not in reset)
//   btn_n_o      out  debounced active-low level
//   press_o      out  1-cycle pulse after a debounced 1->0 transition
//   release_o    out  1-cycle pulse after a debounced 0->1 transition
// -----------------------------------------------------------------------------
module button_debouncer
   import caravel_io_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT
) (
   input  logic clk,
   input  logic srst,
   input  logic btn_n_raw_i,
   input  logic pulse_en_i,
   output logic btn_n_o,
   output logic press_o,
   output logic release_o
);

   localparam int              CW       = cnt_width(DEBOUNCE_COUNT);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   sync_s;
   logic                   accept;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], btn_n_raw_i};
      sync_s    = sync_q[SYNC_STAGES-1];
      stable_d  = stable_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;

      // The counter only runs while the synchronised level disagrees with the
      // accepted level; any agreeing cycle restarts the qualification window.
      if (sync_s == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync_s;
         cnt_d    = '0;
         accept   = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      press_d   = accept & ~sync_s & pulse_en_i;
      release_d = accept &  sync_s & pulse_en_i;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         sync_q    <= '1;
         cnt_q     <= '0;
         stable_q  <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_n_o   = stable_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/caravel_input_conditioner.sv
// -----------------------------------------------------------------------------
// caravel_input_conditioner
//   Sits between the user_project_wrapper GPIOs and a game core.
//   - Debounces NUM_BUTTONS active-low buttons and emits press/release pulses.
//   - Synchronises the external active-low reset pin, stretches it by
//     RESET_HOLD cycles and merges it with wb_rst_i into design_reset.
//   - Drives active-low output enables that float the outputs in reset.
// Ports
//   wb_clk_i         in   sole clock
//   wb_rst_i         in   synchronous active-high reset
//   ext_reset_n_raw  in   asynchronous active-low external reset pin
//   btn_n_raw        in   asynchronous active-low buttons, idle high
//   design_reset     out  registered active-high reset for the core
//   btn_n            out  debounced active-low button levels
//   btn_press        out  1-cycle pulse per debounced 1->0 transition
//   btn_release      out  1-cycle pulse per debounced 0->1 transition
//   oeb              out  output enables, all equal to design_reset
// -----------------------------------------------------------------------------
module caravel_input_conditioner
   import caravel_io_pkg::*;
#(
   parameter int NUM_BUTTONS    = DEF_NUM_BUTTONS,
   parameter int NUM_OUTPUTS    = DEF_NUM_OUTPUTS,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
   parameter int RESET_HOLD     = DEF_RESET_HOLD
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   ext_reset_n_raw,
   input  logic [NUM_BUTTONS-1:0] btn_n_raw,
   output logic                   design_reset,
   output logic [NUM_BUTTONS-1:0] btn_n,
   output logic [NUM_BUTTONS-1:0] btn_press,
   output logic [NUM_BUTTONS-1:0] btn_release,
   output logic [NUM_OUTPUTS-1:0] oeb
);

   localparam int            HW        = cnt_width(RESET_HOLD);
   localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);

   logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic                   design_reset_q, design_reset_d;
   rst_phase_e             rst_phase;
   logic                   pulse_en;

   // Reset sequencer. The synchroniser resets to 0 so that wb_rst_i behaves
   // like an external reset that is still working its way through the chain.
   always_comb begin
      ext_sync_d     = {ext_sync_q[SYNC_STAGES-2:0], ext_reset_n_raw};
      hold_d         = hold_q;
      design_reset_d = design_reset_q;

      if (!ext_sync_q[SYNC_STAGES-1]) begin
         rst_phase = RST_EXT;
      end else if (hold_q != '0) begin
         rst_phase = RST_HOLD;
      end else begin
         rst_phase = RST_RUN;
      end

      case (rst_phase)
         RST_EXT: begin
            hold_d         = HOLD_INIT;
            design_reset_d = 1'b1;
         end
         RST_HOLD: begin
            hold_d         = hold_q - HW'(1);
            design_reset_d = 1'b1;
         end
         default: begin
            design_reset_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ext_sync_q     <= '0;
         hold_q         <= HOLD_INIT;
         design_reset_q <= 1'b1;
      end else begin
         ext_sync_q     <= ext_sync_d;
         hold_q         <= hold_d;
         design_reset_q <= design_reset_d;
      end
   end

   // A pulse is only registered when design_reset is low both before and
   // after this edge, so no pulse is ever visible alongside design_reset=1,
   // including the cycle in which reset is (re)asserted or just released.
   assign pulse_en = ~design_reset_q & ~design_reset_d;

   // Debouncing keeps running during an external reset so the levels are
   // already valid when the core comes out of reset.
   for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      button_debouncer #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
      ) u_debouncer (
         .clk         (wb_clk_i),
         .srst        (wb_rst_i),
         .btn_n_raw_i (btn_n_raw[gi]),
         .pulse_en_i  (pulse_en),
         .btn_n_o     (btn_n[gi]),
         .press_o     (btn_press[gi]),
         .release_o   (btn_release[gi])
      );
   end

   assign design_reset = design_reset_q;
   assign oeb          = {NUM_OUTPUTS{design_reset_q}};

endmodule

// File: tb/tb_caravel_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_caravel_input_conditioner
//   Directed scenarios with literal expectations, then randomized stimulus.
//   A reference model records every sampled input by edge number and derives
//   the outputs from time-window rules; a negedge process compares each cycle.
// -----------------------------------------------------------------------------
module tb_caravel_input_conditioner;

   localparam int NB   = 4;
   localparam int NO   = 6;
   localparam int SS   = 2;
   localparam int DC   = 4;
   localparam int RH   = 3;
   localparam int MAXE = 4096;

   logic          clk = 1'b0;
   logic          wb_rst = 1'b1;
   logic          ext_n = 1'b1;
   logic [NB-1:0] btn_raw = '1;
   logic          design_reset;
   logic [NB-1:0] btn_n, press, rel;
   logic [NO-1:0] oeb;

   always #5 clk = ~clk;

   caravel_input_conditioner #(
      .NUM_BUTTONS    (NB),
      .NUM_OUTPUTS    (NO),
      .SYNC_STAGES    (SS),
      .DEBOUNCE_COUNT (DC),
      .RESET_HOLD     (RH)
   ) dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (wb_rst),
      .ext_reset_n_raw (ext_n),
      .btn_n_raw       (btn_raw),
      .design_reset    (design_reset),
      .btn_n           (btn_n),
      .btn_press       (press),
      .btn_release     (rel),
      .oeb             (oeb)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit            rst_h [MAXE];
   bit            ext_h [MAXE];
   logic [NB-1:0] btn_h [MAXE];
   bit            dr_h  [MAXE];
   int            edge_n  = 0;
   bit            started = 1'b0;
   logic [NB-1:0] m_stable = '1;
   logic [NB-1:0] m_press  = '0;
   logic [NB-1:0] m_rel    = '0;
   int            m_run [NB];
   bit            m_dr = 1'b1;

   // design_reset after edge t: a wb reset within the last SS+RH edges, or an
   // external low sample that is between SS and SS+RH edges old.
   function automatic bit dr_at(input int t);
      for (int k = 0; k <= SS + RH; k++)
         if (t - k >= 1 && rst_h[t-k]) return 1'b1;
      for (int k = SS; k <= SS + RH; k++)
         if (t - k >= 1 && !ext_h[t-k]) return 1'b1;
      return 1'b0;
   endfunction

   // Synchronised button level seen at edge t: the raw sample from SS edges
   // earlier, unless a wb reset in between flushed the chain to idle-high.
   function automatic bit sync_at(input int i, input int t);
      if (t - SS < 1) return 1'b1;
      for (int k = 1; k <= SS; k++)
         if (rst_h[t-k]) return 1'b1;
      return btn_h[t-SS][i];
   endfunction

   task automatic model_step();
      bit s;
      if (edge_n >= MAXE - 1) return;
      edge_n++;
      rst_h[edge_n] = wb_rst;
      ext_h[edge_n] = ext_n;
      btn_h[edge_n] = btn_raw;
      dr_h[edge_n]  = dr_at(edge_n);
      m_press = '0;
      m_rel   = '0;
      if (wb_rst) begin
         started  = 1'b1;
         m_stable = '1;
         for (int i = 0; i < NB; i++) m_run[i] = 0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            s = sync_at(i, edge_n);
            if (s != m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == DC) begin
                  m_stable[i] = s;
                  m_run[i]    = 0;
                  if (!dr_h[edge_n-1] && !dr_h[edge_n]) begin
                     if (s) m_rel[i] = 1'b1;
                     else   m_press[i] = 1'b1;
                  end
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      m_dr = dr_h[edge_n];
   endtask

   initial begin
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("cyc_design_reset", {31'd0, design_reset}, {31'd0, m_dr});
            chk("cyc_oeb", {26'd0, oeb}, {26'd0, {NO{m_dr}}});
            chk("cyc_btn_n", {28'd0, btn_n}, {28'd0, m_stable});
            chk("cyc_btn_press", {28'd0, press}, {28'd0, m_press});
            chk("cyc_btn_release", {28'd0, rel}, {28'd0, m_rel});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // 1: reset for 3 edges, release, design_reset falls on the 6th edge
      wb_rst = 1'b1;
      tick(3);
      chk("t1_dr_in_reset", {31'd0, design_reset}, 32'd1);
      chk("t1_oeb_in_reset", {26'd0, oeb}, 32'h3F);
      chk("t1_btn_n_reset", {28'd0, btn_n}, 32'hF);
      chk("t1_press_reset", {28'd0, press}, 32'h0);
      wb_rst = 1'b0;
      tick(5);
      chk("t1_dr_edge5", {31'd0, design_reset}, 32'd1);
      tick(1);
      chk("t1_dr_edge6", {31'd0, design_reset}, 32'd0);
      chk("t1_oeb_edge6", {26'd0, oeb}, 32'h0);

      // 2: press and release of button 1
      btn_raw[1] = 1'b0;
      tick(5);
      chk("t2_btn_n_edge5", {28'd0, btn_n}, 32'hF);
      tick(1);
      chk("t2_btn_n_edge6", {28'd0, btn_n}, 32'hD);
      chk("t2_press", {28'd0, press}, 32'h2);
      tick(1);
      chk("t2_press_gone", {28'd0, press}, 32'h0);
      btn_raw[1] = 1'b1;
      tick(5);
      chk("t2_btn_n_held", {28'd0, btn_n}, 32'hD);
      tick(1);
      chk("t2_btn_n_up", {28'd0, btn_n}, 32'hF);
      chk("t2_release", {28'd0, rel}, 32'h2);

      // 3: short glitch rejected, 4-cycle low accepted
      btn_raw[0] = 1'b0;
      tick(3);
      btn_raw[0] = 1'b1;
      tick(8);
      chk("t3_glitch_btn_n", {28'd0, btn_n}, 32'hF);
      btn_raw[0] = 1'b0;
      tick(4);
      btn_raw[0] = 1'b1;
      tick(2);
      chk("t3_accept_btn_n", {28'd0, btn_n}, 32'hE);
      chk("t3_accept_press", {28'd0, press}, 32'h1);
      tick(12);
      chk("t3_back_high", {28'd0, btn_n}, 32'hF);

      // 4: one-cycle external reset pulse
      ext_n = 1'b0;
      tick(1);
      ext_n = 1'b1;
      tick(1);
      chk("t4_dr_edge2", {31'd0, design_reset}, 32'd0);
      tick(1);
      chk("t4_dr_edge3", {31'd0, design_reset}, 32'd1);
      chk("t4_oeb_edge3", {26'd0, oeb}, 32'h3F);
      tick(3);
      chk("t4_dr_edge6", {31'd0, design_reset}, 32'd1);
      tick(1);
      chk("t4_dr_edge7", {31'd0, design_reset}, 32'd0);
      chk("t4_oeb_edge7", {26'd0, oeb}, 32'h0);

      // 5: all buttons together, then again under external reset
      btn_raw = '0;
      tick(5);
      chk("t5_btn_n_edge5", {28'd0, btn_n}, 32'hF);
      tick(1);
      chk("t5_btn_n_all", {28'd0, btn_n}, 32'h0);
      chk("t5_press_all", {28'd0, press}, 32'hF);
      tick(1);
      chk("t5_press_gone", {28'd0, press}, 32'h0);
      btn_raw = '1;
      tick(10);
      ext_n   = 1'b0;
      btn_raw = '0;
      tick(1);
      ext_n = 1'b1;
      tick(5);
      chk("t5r_btn_n", {28'd0, btn_n}, 32'h0);
      chk("t5r_press", {28'd0, press}, 32'h0);
      chk("t5r_dr", {31'd0, design_reset}, 32'd1);
      tick(1);
      chk("t5r_dr_release", {31'd0, design_reset}, 32'd0);
      chk("t5r_press_after", {28'd0, press}, 32'h0);
      btn_raw = '1;
      tick(10);

      // 6: wb reset in the middle of debouncing button 2
      btn_raw[2] = 1'b0;
      tick(4);
      wb_rst = 1'b1;
      tick(1);
      wb_rst = 1'b0;
      chk("t6_btn_n_cleared", {28'd0, btn_n}, 32'hF);
      chk("t6_dr_set", {31'd0, design_reset}, 32'd1);
      tick(5);
      chk("t6_btn_n_edge5", {28'd0, btn_n}, 32'hF);
      chk("t6_dr_edge5", {31'd0, design_reset}, 32'd1);
      tick(1);
      chk("t6_btn_n_edge6", {28'd0, btn_n}, 32'hB);
      chk("t6_no_press", {28'd0, press}, 32'h0);
      chk("t6_dr_edge6", {31'd0, design_reset}, 32'd0);
      btn_raw[2] = 1'b1;
      tick(10);

      // Randomized phase: bouncy buttons, occasional resets of both kinds
      for (int c = 0; c < 2000; c++) begin
         wb_rst = ($urandom_range(0, 299) == 0);
         ext_n  = ($urandom_range(0, 79) != 0);
         for (int i = 0; i < NB; i++)
            if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
         tick(1);
      end
      wb_rst  = 1'b0;
      ext_n   = 1'b1;
      btn_raw = '1;
      tick(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
